// File: rtl/shift_exec_unit.sv
// -----------------------------------------------------------------------------
// shift_exec_unit -- two-register pipelined shift execution unit (EX stage)
//
// Purpose:
//   Decodes the R-type shift funct field, picks the shift amount (shamt field
//   or rs[4:0]) and runs the operand through a combinational right shifter.
//   Left shifts reuse the right shifter by bit-reversing operand and result.
//   The result and its destination tag are handed to writeback under a
//   valid/ready handshake.
//
// Configuration:
//   SHIFT_ROTR_EN - when defined, SRL/SRLV with in_rot=1 rotate right, and
//                   SRA/SRAV with in_rot=1 are flagged illegal. When not
//                   defined, in_rot is ignored and no rotate logic exists.
//
// Ports (shift_exec_unit):
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of both pipeline stages
//   in_valid     operation offered
//   in_ready     unit can take the offered operation this cycle
//   in_funct     R-type funct field
//   in_shamt     instruction shamt field
//   in_rot       rotate modifier (only meaningful with SHIFT_ROTR_EN)
//   in_rs        rs operand, bits [4:0] give the variable shift amount
//   in_rt        rt operand, the value being shifted
//   in_tag       destination register tag
//   out_valid    result available
//   out_ready    downstream accepts the result
//   out_result   shift result (0 for illegal ops)
//   out_tag      tag travelling with the result
//   out_illegal  funct was not a supported shift
//
// Ports (rshifter_32, combinational helper):
//   x      value to shift
//   shamt  shift amount 0..31
//   arith  1 = fill with x[31], 0 = fill with zeros
//   z      shifted value
// -----------------------------------------------------------------------------

module rshifter_32 (
  input  logic [31:0] x,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] z
);

  logic fill;
  assign fill = arith & x[31];

  // Logarithmic barrel shifter: stage gi shifts by 2**gi when shamt[gi] set.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [31:0] src;
      logic [31:0] v;
      if (gi == 0) begin : g_first
        assign src = x;
      end else begin : g_next
        assign src = g_stage[gi-1].v;
      end
      assign v = shamt[gi] ? {{SH{fill}}, src[31:SH]} : src;
    end
  endgenerate

  assign z = g_stage[4].v;

endmodule

module shift_exec_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic             in_rot,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Operation class carried in S1. OP_ROR only appears with SHIFT_ROTR_EN.
  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROR = 3'd3,
    OP_ILL = 3'd4
  } op_e;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             s1_valid_reg;
  op_e              s1_op_reg;
  logic [4:0]       s1_amt_reg;
  logic [31:0]      s1_rt_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [31:0]      out_result_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             out_illegal_reg;

  // ---------------------------------------------------------------------------
  // Handshake. in_ready depends only on state and out_ready, never on in_valid.
  // ---------------------------------------------------------------------------
  logic s2_free;
  logic in_accept;
  logic s1_advance;

  assign s2_free    = !s2_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_free;
  assign in_accept  = in_valid && in_ready;
  assign s1_advance = s1_valid_reg && s2_free;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  op_e        op_next;
  logic [4:0] amt_next;

  always_comb begin
    op_next  = OP_ILL;
    amt_next = 5'd0;
    case (in_funct)
      F_SLL:  begin op_next = OP_SLL; amt_next = in_shamt;   end
      F_SRL:  begin op_next = OP_SRL; amt_next = in_shamt;   end
      F_SRA:  begin op_next = OP_SRA; amt_next = in_shamt;   end
      F_SLLV: begin op_next = OP_SLL; amt_next = in_rs[4:0]; end
      F_SRLV: begin op_next = OP_SRL; amt_next = in_rs[4:0]; end
      F_SRAV: begin op_next = OP_SRA; amt_next = in_rs[4:0]; end
      default: begin op_next = OP_ILL; amt_next = 5'd0;      end
    endcase
`ifdef SHIFT_ROTR_EN
    // The rotate modifier turns logical right shifts into rotates; an
    // arithmetic rotate has no meaning, so it is rejected as illegal.
    if (in_rot) begin
      if (op_next == OP_SRL) begin
        op_next = OP_ROR;
      end else if (op_next == OP_SRA) begin
        op_next  = OP_ILL;
        amt_next = 5'd0;
      end
    end
`endif
  end

  // Upper rs bits never influence the amount; collected here so they read
  // as intentionally unused.
`ifdef SHIFT_ROTR_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, in_rs[31:5]};
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, in_rs[31:5], in_rot};
`endif

  // ---------------------------------------------------------------------------
  // Datapath between S1 and S2
  // ---------------------------------------------------------------------------
  logic [31:0] rt_rev;
  logic [31:0] sh_x;
  logic        sh_arith;
  logic [31:0] sh_z;
  logic [31:0] sh_z_rev;
  logic        is_left;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign rt_rev[gi]   = s1_rt_reg[31-gi];
      assign sh_z_rev[gi] = sh_z[31-gi];
    end
  endgenerate

  // Left shift = reverse, shift right with zero fill, reverse back.
  assign is_left  = (s1_op_reg == OP_SLL);
  assign sh_x     = is_left ? rt_rev : s1_rt_reg;
  assign sh_arith = (s1_op_reg == OP_SRA);

  rshifter_32 u_rshift (
    .x     (sh_x),
    .shamt (s1_amt_reg),
    .arith (sh_arith),
    .z     (sh_z)
  );

`ifdef SHIFT_ROTR_EN
  // Rotate right = (rt >> amt) | (rt << (32-amt)). The left half is a second
  // right shifter on the reversed operand. For amt=0 the 5-bit complement
  // amount is also 0, so both halves equal rt and the OR returns rt.
  logic [4:0]  rot_amt;
  logic [31:0] rot_z;
  logic [31:0] rot_left;

  assign rot_amt = 5'd0 - s1_amt_reg;

  rshifter_32 u_rshift_rot (
    .x     (rt_rev),
    .shamt (rot_amt),
    .arith (1'b0),
    .z     (rot_z)
  );

  generate
    for (gi = 0; gi < 32; gi++) begin : g_rot_rev
      assign rot_left[gi] = rot_z[31-gi];
    end
  endgenerate
`endif

  logic [31:0] result_next;
  logic        illegal_next;

  always_comb begin
    result_next  = 32'd0;
    illegal_next = 1'b0;
    case (s1_op_reg)
      OP_SLL: result_next = sh_z_rev;
      OP_SRL: result_next = sh_z;
      OP_SRA: result_next = sh_z;
`ifdef SHIFT_ROTR_EN
      OP_ROR: result_next = sh_z | rot_left;
`endif
      default: begin
        result_next  = 32'd0;
        illegal_next = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_op_reg       <= OP_SLL;
      s1_amt_reg      <= 5'd0;
      s1_rt_reg       <= 32'd0;
      s1_tag_reg      <= '0;
      s2_valid_reg    <= 1'b0;
      out_result_reg  <= 32'd0;
      out_tag_reg     <= '0;
      out_illegal_reg <= 1'b0;
    end else if (flush) begin
      // Kill everything in flight; data registers may keep stale contents.
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      // S2: load from S1 whenever it is free; otherwise hold (stall).
      if (s2_free) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_result_reg  <= result_next;
          out_tag_reg     <= s1_tag_reg;
          out_illegal_reg <= illegal_next;
        end
      end
      // S1: a new op can enter in the same cycle the old one moves to S2.
      if (in_accept) begin
        s1_valid_reg <= 1'b1;
        s1_op_reg    <= op_next;
        s1_amt_reg   <= amt_next;
        s1_rt_reg    <= in_rt;
        s1_tag_reg   <= in_tag;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_result  = out_result_reg;
  assign out_tag     = out_tag_reg;
  assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_shift_exec_unit.sv
module tb_shift_exec_unit;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_funct;
  logic [4:0]       in_shamt;
  logic             in_rot;
  logic [31:0]      in_rs;
  logic [31:0]      in_rt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  shift_exec_unit #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rot      (in_rot),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Monitor: a result is consumed when out_valid && out_ready at an edge;
  // sample mid-cycle, before that edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got tag=%0d res=%h required no output", out_tag, out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out tag=%0d res=%h ill=%0b (req res=%h ill=%0b)", out_tag, out_result, out_illegal, e.res, e.ill);
        check("out_result", out_result, e.res);
        check("out_tag", 32'(out_tag), 32'(e.tag));
        check("out_illegal", 32'(out_illegal), 32'(e.ill));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Offer one op and hold it until accepted; queue the expected response.
  task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic rot,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp_res, input logic exp_ill);
    logic r;
    int   n;
    exp_t e;
    in_funct = f; in_shamt = sh; in_rot = rot; in_rs = rs; in_rt = rt; in_tag = tag;
    in_valid = 1'b1;
    n = 0;
    #1;
    forever begin
      r = in_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: tag=%0d got no accept required accept", tag);
        #1 in_valid = 1'b0;
        return;
      end
      #2;
    end
    e.res = exp_res; e.tag = tag; e.ill = exp_ill;
    sb.push_back(e);
    $display("in  tag=%0d funct=%b shamt=%0d rs=%h rt=%h", tag, f, sh, rs, rt);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_funct = 6'b000000; in_shamt = 5'd31; in_rot = 1'b0;
    in_rs = 32'd0; in_rt = 32'h1; in_tag = 5'd1;

    // Reset with in_valid held high.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First op after reset: absent one edge after accept, present after two.
    issue(6'b000000, 5'd31, 1'b0, 32'd0, 32'h1, 5'd1, 32'h80000000, 1'b0);
    @(negedge clk);
    check("lat_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_on_time", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back with out_ready high.
    pop_cyc.delete();
    issue(6'b000000, 5'd31, 1'b0, 32'd0, 32'h00000001, 5'd2, 32'h80000000, 1'b0);
    issue(6'b000011, 5'd8,  1'b0, 32'd0, 32'h80000d2c, 5'd3, 32'hff80000d, 1'b0);
    issue(6'b000010, 5'd9,  1'b0, 32'd0, 32'h80000d2c, 5'd4, 32'h00400006, 1'b0);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // Variable shifts and boundaries.
    issue(6'b000111, 5'd0,  1'b0, 32'hffffffe3, 32'hffffff56, 5'd5, 32'hffffffea, 1'b0);
    issue(6'b000110, 5'd0,  1'b0, 32'hffffffe3, 32'hffffff56, 5'd6, 32'h1fffffea, 1'b0);
    issue(6'b000100, 5'd7,  1'b0, 32'h00000020, 32'h000000aa, 5'd7, 32'h000000aa, 1'b0);
    issue(6'b000000, 5'd4,  1'b0, 32'd0,        32'h12345678, 5'd8, 32'h23456780, 1'b0);
    issue(6'b000011, 5'd31, 1'b0, 32'd0,        32'h80000000, 5'd9, 32'hffffffff, 1'b0);
    issue(6'b000100, 5'd0,  1'b0, 32'hffffffe1, 32'h80000001, 5'd10, 32'h00000002, 1'b0);
    issue(6'b000010, 5'd0,  1'b0, 32'd0,        32'hdeadbeef, 5'd11, 32'hdeadbeef, 1'b0);
    drain();

    // Backpressure.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(6'b000010, 5'd4,  1'b0, 32'd0, 32'h000000f0, 5'd12, 32'h0000000f, 1'b0);
    issue(6'b000000, 5'd8,  1'b0, 32'd0, 32'h0000000f, 5'd13, 32'h00000f00, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_result_stable", out_result, 32'h0000000f);
      check("bp_out_tag_stable", 32'(out_tag), 32'd12);
    end
    fork
      issue(6'b000011, 5'd30, 1'b0, 32'd0, 32'h7fffffff, 5'd14, 32'h00000001, 1'b0);
      begin
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Illegal funct.
    issue(6'b100000, 5'd3, 1'b0, 32'd0, 32'h12345678, 5'd21, 32'h00000000, 1'b1);
    drain();

    // Rotate modifier.
`ifdef SHIFT_ROTR_EN
    issue(6'b000010, 5'd1, 1'b1, 32'd0, 32'h00000001, 5'd22, 32'h80000000, 1'b0);
    issue(6'b000011, 5'd4, 1'b1, 32'd0, 32'h80000000, 5'd23, 32'h00000000, 1'b1);
    issue(6'b000110, 5'd0, 1'b1, 32'h00000000, 32'h89abcdef, 5'd24, 32'h89abcdef, 1'b0);
`else
    issue(6'b000010, 5'd1, 1'b1, 32'd0, 32'h00000001, 5'd22, 32'h00000000, 1'b0);
    issue(6'b000011, 5'd4, 1'b1, 32'd0, 32'h80000000, 5'd23, 32'hf8000000, 1'b0);
    issue(6'b000110, 5'd0, 1'b1, 32'h00000000, 32'h89abcdef, 5'd24, 32'h89abcdef, 1'b0);
`endif
    drain();

    // Flush with both stages full and a new op offered.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(6'b000000, 5'd1, 1'b0, 32'd0, 32'h00000003, 5'd25, 32'h00000006, 1'b0);
    issue(6'b000010, 5'd1, 1'b0, 32'd0, 32'h00000006, 5'd26, 32'h00000003, 1'b0);
    in_funct = 6'b000000; in_shamt = 5'd2; in_rt = 32'h1; in_tag = 5'd27;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_nothing_emerges", 32'(out_valid), 32'd0);
    end

    // Pipeline still usable after flush.
    issue(6'b000000, 5'd16, 1'b0, 32'd0, 32'h0000abcd, 5'd28, 32'habcd0000, 1'b0);
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Two-register pipelined shift execution unit for the EX stage of the 32-bit MIPS-style datapath.
- Decodes the R-type shift funct field and selects the shift amount (immediate shamt or rs[4:0]).
- Drives an instance of the existing combinational rshifter_32 (ports x, shamt, arith, z); left shifts are done by bit-reversing around it.
- Passes a registered result plus destination tag downstream to writeback under valid/ready flow control.

Parameters:
TAG_W, 5, width of the destination-register tag carried alongside each operation

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous pipeline kill (branch mispredict/exception)
in_valid  input  1  operation offered
in_ready  output  1  unit can accept the offered operation this cycle
in_funct  input  6  R-type funct field
in_shamt  input  5  instruction shamt field
in_rot  input  1  rotate modifier bit (used only with SHIFT_ROTR_EN)
in_rs  input  32  rs operand (variable shift amount source)
in_rt  input  32  rt operand (value being shifted)
in_tag  input  TAG_W  destination register tag
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  32  shift result
out_tag  output  TAG_W  tag of the result
out_illegal  output  1  funct was not a supported shift

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_result=0, out_tag=0, out_illegal=0. Pipeline data registers are also cleared to 0.
- Decode of funct:
  - 000000 SLL: amount = in_shamt.
  - 000010 SRL: amount = in_shamt.
  - 000011 SRA: amount = in_shamt.
  - 000100 SLLV: amount = in_rs[4:0].
  - 000110 SRLV: amount = in_rs[4:0].
  - 000111 SRAV: amount = in_rs[4:0].
  - Only bits [4:0] of rs are used; upper rs bits are ignored.
- Stage S1 register:
  - Captures decoded op class (left/logical-right/arith-right/illegal), 5-bit amount, rt, tag, on edge where in_valid && in_ready.
- Datapath between S1 and S2:
  - Right shifts: rshifter_32(x=rt, shamt=amount, arith=1 for SRA/SRAV only).
  - Left shifts: x=bitreverse(rt), arith=0, result=bitreverse(z).
  - Amount 0 returns rt unchanged for every op.
- Stage S2 register: captures result, tag, illegal flag from S1 when S1 valid and S2 can accept.
- Illegal funct:
  - The operation still flows through the pipeline with out_illegal=1 and out_result=0.
  - It is never dropped.
- Handshake:
  - s2_free = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - in_ready has no combinational path from in_valid.
- Latency: op accepted at edge k is on out_* after edge k+1 when not stalled. Full throughput is 1 op/cycle.
- Stall:
  - out_valid held with out_ready low: out_result/out_tag/out_illegal stay stable.
  - S1 holds its contents and in_ready drops when S1 is also occupied.
- Simultaneous S2 drain and S1 advance in the same cycle is allowed; no bubble is inserted.
- flush high at an edge:
  - s1_valid and s2_valid cleared; any in_valid that cycle is not accepted.
  - flush takes priority over all other updates.
  - out_result is not required to clear.
- Reset mid-operation: all in-flight ops discarded immediately, outputs go to reset values.
- out_valid is s2_valid directly from the register.

Optional Feature:
- SHIFT_ROTR_EN defined:
  - SRL/SRLV with in_rot=1 perform rotate-right by amount: result = (rt >> amt) | (rt << (32-amt)). Built from two rshifter_32 paths or equivalent; amount 0 returns rt.
  - SRA/SRAV with in_rot=1 are illegal.
- Not defined:
  - in_rot is ignored entirely; SRL/SRLV with in_rot=1 behave as plain logical shifts.
  - No rotate logic is synthesized.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, out_result=0, out_tag=0 during reset. First accepted op appears exactly one edge after acceptance following reset release.
- Back-to-back, out_ready=1:
  - SLL rt=0x1 shamt=31 → 0x80000000.
  - SRA rt=0x80000d2c shamt=8 → 0xff80000d.
  - SRL rt=0x80000d2c shamt=9 → 0x00400006.
  - Results arrive on consecutive cycles, tags in order.
- SRAV rs=0xffffffe3 (amt 3) rt=0xffffff56 → 0xffffffea; SRLV same operands → 0x1fffffea; SLLV rs=0x20 (amt 0) rt=0xaa → 0xaa.
- Backpressure: out_ready=0 for 3 cycles while issuing 3 ops → in_ready drops after 2 accepted, out_* stable. Releasing out_ready drains all 3 in order with no loss or duplication.
- funct=100000 → out_illegal=1, out_result=0, tag preserved. Flush asserted with S1 and S2 full plus in_valid=1 → out_valid=0 next cycle, nothing from those ops emerges.
- With SHIFT_ROTR_EN: SRL in_rot=1 rt=0x1 shamt=1 → 0x80000000. Without it, the same op → 0x00000000.
